// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: round-robin write arbiter in front of a FIFO, plus a read
// sequencer that waits a programmable delay, pops one word, and holds it on
// a valid/ready output until it is taken.
//
// Read sequencer states:
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | no read in flight; leaves when the FIFO reports data
//   ST_WAIT    | counting down rd_delay before the read
//   ST_READ    | one-cycle fifo_read_en strobe (skipped if FIFO went empty)
//   ST_CAPTURE | FIFO data valid this cycle; latched into out_data
//   ST_HOLD    | out_valid high, waiting for out_ready
module fifo_arb_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int DELAY_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic                          fifo_read_en,
    input  logic [DATA_WIDTH-1:0]         fifo_data_out,
    input  logic [DELAY_WIDTH-1:0]        rd_delay,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_HOLD
    } rd_state_t;

    logic [GW-1:0]          last_grant_q, last_grant_d;
    rd_state_t              state_q, state_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];

    // Unpack the flat requester data bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin grant: search starts one past the last winner and wraps.
    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        last_grant_d  = last_grant_q;
        found         = 1'b0;
        idx           = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = GW'((int'(last_grant_q) + 1 + k) % NUM_REQ);
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    req_ready[idx] = 1'b1;
                    fifo_write_en  = 1'b1;
                    fifo_data_in   = req_word[idx];
                    last_grant_d   = idx;
                end
            end
        end
    end

    // Read sequencer next-state, delay counter and output holding register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        fifo_read_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (rd_delay == '0) begin
                        state_d = ST_READ;
                    end else begin
                        cnt_d   = rd_delay;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - DELAY_WIDTH'(1);
                // <= rather than == so a corrupted zero count cannot wrap.
                if (cnt_q <= DELAY_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!fifo_empty) begin
                    fifo_read_en = 1'b1;
                    state_d      = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                out_data_d  = fifo_data_out;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset parks the arbiter so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign grant_id  = last_grant_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a timestamp-based reference model.
module tb_fifo_arb_ctrl;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int DLW = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_write_en;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_read_en;
    logic [DW-1:0]     fifo_data_out;
    logic [DLW-1:0]    rd_delay;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [$clog2(N)-1:0] grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: write side is "last winner", read side is a set of
    // timestamps (when the read is due, when the capture is due).
    int          m_cyc;
    int          m_last;
    bit          m_busy;
    int          m_read_at;
    int          m_cap_at;
    bit          m_valid;
    logic [DW-1:0] m_out;

    fifo_arb_ctrl #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .DELAY_WIDTH(DLW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data_out(fifo_data_out),
        .rd_delay     (rd_delay),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_last    = N - 1;
        m_busy    = 1'b0;
        m_read_at = -1;
        m_cap_at  = -1;
        m_valid   = 1'b0;
        m_out     = '0;
    endtask

    // Called at a falling edge with inputs already driven; compares all
    // outputs, advances the model over the rising edge, returns at the next
    // falling edge.
    task automatic do_cycle();
        int           g;
        int           idx;
        logic [N-1:0] e_ready;
        logic         e_rd;
        #1;
        g = -1;
        if (!fifo_full) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_last + 1 + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(e_ready));
        check_val("fifo_write_en", 32'(fifo_write_en), 32'(g >= 0));
        if (g >= 0) check_val("fifo_data_in", 32'(fifo_data_in), 32'(req_data[g*DW +: DW]));
        check_val("grant_id", 32'(grant_id), 32'(m_last));
        e_rd = m_busy && (m_cyc == m_read_at) && !fifo_empty;
        check_val("fifo_read_en", 32'(fifo_read_en), 32'(e_rd));
        check_val("out_valid", 32'(out_valid), 32'(m_valid));
        check_val("out_data", 32'(out_data), 32'(m_out));
        @(posedge clk);
        if (g >= 0) m_last = g;
        if (!m_busy) begin
            if (!fifo_empty) begin
                m_busy    = 1'b1;
                m_read_at = m_cyc + 1 + int'(rd_delay);
                m_cap_at  = -1;
            end
        end else if (m_cyc == m_read_at) begin
            if (fifo_empty) m_busy = 1'b0;
            else            m_cap_at = m_cyc + 1;
        end else if (m_cyc == m_cap_at) begin
            m_valid = 1'b1;
            m_out   = fifo_data_out;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid  = '0;
        fifo_empty = 1'b1;
        out_ready  = 1'b1;
        repeat (20) do_cycle();
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear
    // before any rising edge arrives.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'(0));
        check_val("rst_grant_id", 32'(grant_id), 32'(N - 1));
        check_val("rst_read_en", 32'(fifo_read_en), 32'(0));
        check_val("rst_out_data", 32'(out_data), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        fifo_full     = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        rd_delay      = '0;
        out_ready     = 1'b0;
        m_cyc         = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("reset_grant_id", 32'(grant_id), 32'(N - 1));
        check_val("reset_out_valid", 32'(out_valid), 32'(0));
        check_val("reset_out_data", 32'(out_data), 32'(0));
        check_val("reset_read_en", 32'(fifo_read_en), 32'(0));
        rst_n = 1'b1;

        // Round robin with every requester asking.
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            req_data = (N*DW)'($urandom);
            do_cycle();
            check_val("rr_order", 32'(grant_id), 32'(i % N));
        end

        // Backpressure, then release: 0 before 2.
        fifo_full = 1'b1;
        req_valid = 4'b0101;
        repeat (3) do_cycle();
        fifo_full = 1'b0;
        do_cycle();
        check_val("bp_first", 32'(grant_id), 32'(0));
        do_cycle();
        check_val("bp_second", 32'(grant_id), 32'(2));
        drain();

        // Delay of 3 with a stalled consumer.
        rd_delay   = 4'd3;
        fifo_empty = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fifo_data_out = DW'($urandom);
            do_cycle();
        end
        out_ready = 1'b1;
        do_cycle();
        drain();

        // Zero delay, consumer stalled for several cycles, then one pulse.
        rd_delay   = '0;
        fifo_empty = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fifo_data_out = DW'($urandom);
            do_cycle();
        end
        out_ready  = 1'b1;
        do_cycle();
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        repeat (3) do_cycle();
        drain();

        // FIFO empties while waiting: the read must be skipped.
        rd_delay   = 4'd3;
        fifo_empty = 1'b0;
        do_cycle();
        fifo_empty = 1'b1;
        repeat (8) do_cycle();
        drain();

        // Reset while holding a word.
        req_valid = 4'b0010;
        do_cycle();
        req_valid  = '0;
        rd_delay   = '0;
        fifo_empty = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fifo_data_out = DW'($urandom);
            do_cycle();
        end
        check_val("pre_rst_valid", 32'(out_valid), 32'(1));
        check_val("pre_rst_grant", 32'(grant_id), 32'(1));
        async_reset_pulse();
        fifo_empty = 1'b1;
        repeat (3) do_cycle();

        // Randomized traffic with occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            req_valid     = N'($urandom);
            req_data      = (N*DW)'($urandom);
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = ($urandom_range(0, 9) < 3);
            fifo_data_out = DW'($urandom);
            out_ready     = ($urandom_range(0, 9) < 4);
            rd_delay      = ($urandom_range(0, 19) == 0) ? DLW'(15) : DLW'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            else                            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 4: data word width, matching the attached FIFO.
REQ-003 Parameter DELAY_WIDTH, default 4: width of the read-delay setting.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot accept; a word transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 fifo_write_en  output  1  FIFO write strobe.
REQ-010 fifo_data_in  output  DATA_WIDTH  FIFO write data.
REQ-011 fifo_full / fifo_empty  input  1 each  FIFO status flags.
REQ-012 fifo_read_en  output  1  FIFO read strobe.
REQ-013 fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_read_en.
REQ-014 rd_delay  input  DELAY_WIDTH  wait cycles inserted before each FIFO read.
REQ-015 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-016 out_data  output  DATA_WIDTH  downstream data.
REQ-017 grant_id  output  clog2(NUM_REQ)  index of the last granted requester.

Function
REQ-018 The write side is combinational from req_valid, fifo_full and the registered last_grant pointer. Priority search starts at (last_grant+1) mod NUM_REQ and wraps.
REQ-019 When fifo_full=0 and any req_valid is set, exactly one req_ready is high (the first valid requester in search order), fifo_write_en=1, and fifo_data_in equals that requester's data.
REQ-020 When fifo_full=1 or no req_valid is set, req_ready is all-zero and fifo_write_en=0.
REQ-021 On each cycle with fifo_write_en=1, last_grant (and therefore grant_id) updates at the clock edge to the granted index. Otherwise last_grant holds.
REQ-022 The read side is an FSM with states IDLE, WAIT, READ, CAPTURE, HOLD.
REQ-023 IDLE:
- fifo_empty=0 and rd_delay=0: go to READ.
- fifo_empty=0 and rd_delay>0: load cnt=rd_delay and go to WAIT.
- Otherwise stay in IDLE.
REQ-024 WAIT: cnt decrements each cycle; the FSM goes to READ on the edge where cnt==1. rd_delay changes during WAIT are ignored.
REQ-025 READ: fifo_read_en=1 for exactly this one cycle if fifo_empty=0, then go to CAPTURE. If fifo_empty=1, fifo_read_en stays 0 and the FSM returns to IDLE.
REQ-026 CAPTURE: latch out_data<=fifo_data_out and set out_valid<=1 at the end of the cycle, then go to HOLD.
REQ-027 HOLD: out_valid=1 and out_data stable until out_ready=1. On that edge out_valid<=0 and the FSM goes to IDLE.
REQ-028 Latency: with fifo_empty first seen low in IDLE at cycle t and rd_delay=D:
- fifo_read_en is high in cycle t+1+D;
- out_valid is first high in cycle t+3+D.
REQ-029 fifo_read_en is never high outside READ. At most one FIFO read is outstanding (no read until HOLD completes).
REQ-030 Write and read sides are independent; a simultaneous write grant and fifo_read_en in the same cycle are both permitted.
REQ-031 The cnt width is DELAY_WIDTH; the maximum delay is 2^DELAY_WIDTH-1 cycles with no wrap.

Reset
REQ-032 While rst_n=0, asynchronously and regardless of clock:
- FSM=IDLE, cnt=0, last_grant=NUM_REQ-1;
- grant_id=NUM_REQ-1, out_valid=0, out_data=0, fifo_read_en=0.
REQ-033 Reset asserted mid-WAIT, READ or HOLD abandons the operation; any captured word is discarded, and no FIFO read occurs until rst_n=1 and the IDLE conditions are met again.
REQ-034 After reset, requester 0 has highest write priority.

Verification
REQ-035 Round-robin: all 4 req_valid=1, fifo_full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle, req_ready one-hot.
REQ-036 Backpressure: fifo_full=1 with req_valid=4'b0101 -> req_ready=0 and fifo_write_en=0. Release fifo_full -> requester 0 granted first, then 2.
REQ-037 Delay: rd_delay=3, fifo_empty falls, seen in IDLE at cycle t -> fifo_read_en only in cycle t+4; out_valid rises at t+6 with out_data=fifo_data_out sampled at t+5.
REQ-038 Zero delay and stall: rd_delay=0 with out_ready=0 for 5 cycles -> a single read, out_valid held and out_data stable; a pulse on out_ready returns the FSM to IDLE.
REQ-039 Empty at READ: fifo_empty raised during WAIT -> no fifo_read_en and the FSM returns to IDLE.
REQ-040 Reset mid-HOLD: rst_n low for half a cycle -> out_valid=0 and grant_id=NUM_REQ-1 immediately, with no clock edge required.
